// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the dual-instruction fetch stage.
package fetch_pkg;

  // Width of the PC stored in each queue entry (matches the default PC_W).
  localparam int FETCH_PC_W = 16;
  localparam int PAIR_BYTES = 8;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]           instr1;
    logic [31:0]           instr2;
    logic [FETCH_PC_W-1:0] pc;
    logic                  stream_new;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched instruction pairs with flush.
// Pop on an empty queue is ignored; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_pop;

  assign do_pop = pop && (count_q != '0);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)   tail_q <= tail_q + PW'(1);
      if (do_pop) head_q <= head_q + PW'(1);
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[head_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: dual-instruction fetch stage with pair queue and redirect.
// Optional macro FETCH_BYPASS_EN: show a response combinationally when the
// queue is empty (and consume it without enqueueing if deq_en is high).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              QDEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [63:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            deq_en,
  output logic            pair_valid_o,
  output logic [31:0]     instr1_o,
  output logic [31:0]     instr2_o,
  output logic [PC_W-1:0] pcplus4_o,
  output logic            nextpc_sel_o
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            stream_new_q, stream_new_d;
  logic            skip_q, skip_d;

  logic            accept, rsp_take, bypass, push, pop, outstanding;
  logic [CW-1:0]   count;
  fetch_entry_t    head, entry_in, disp;
  logic            unused_bits;

  assign unused_bits = ^{redirect_pc[1:0], pc_q[2:0]};

  assign imem_req  = (state_q == REQ) && (count < QDEPTH_C);
  assign imem_addr = {pc_q[PC_W-1:3], 3'b000};
  assign accept    = imem_req && imem_ready;
  assign rsp_take  = (state_q == WAIT) && imem_rvalid && !redirect_valid;

  assign entry_in.instr1     = skip_q ? NOP_INSTR : imem_rdata[31:0];
  assign entry_in.instr2     = imem_rdata[63:32];
  assign entry_in.pc         = FETCH_PC_W'(imem_addr);
  assign entry_in.stream_new = stream_new_q;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_take && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed pair consumed by IF/ID in the same cycle never enters the queue.
  assign push = rsp_take && !(bypass && deq_en);
  assign pop  = deq_en && !redirect_valid;

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (entry_in),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  // FSM, PC and stream-flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      stream_new_q <= 1'b0;
      skip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stream_new_q <= stream_new_d;
      skip_q       <= skip_d;
    end
  end

  // Next-state logic; redirect overrides every state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stream_new_d = stream_new_q;
    skip_d       = skip_q;
    // A response is still owed if one is being accepted now or was accepted
    // earlier and does not arrive this cycle.
    outstanding  = accept ||
                   (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid);
    if (redirect_valid) begin
      pc_d         = {redirect_pc[PC_W-1:3], 3'b000};
      stream_new_d = 1'b1;
      skip_d       = redirect_pc[2];
      state_d      = outstanding ? DRAIN : REQ;
    end else begin
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     if (accept) state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            pc_d         = pc_q + PC_W'(PAIR_BYTES);
            stream_new_d = 1'b0;
            skip_d       = 1'b0;
            state_d      = REQ;
          end
        end
        DRAIN:   if (imem_rvalid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // IF/ID outputs from the queue head (or the bypassed response).
  always_comb begin
    disp         = bypass ? entry_in : head;
    pair_valid_o = (count != '0) || bypass;
    instr1_o     = NOP_INSTR;
    instr2_o     = NOP_INSTR;
    pcplus4_o    = '0;
    nextpc_sel_o = 1'b0;
    if (pair_valid_o) begin
      instr1_o     = disp.instr1;
      instr2_o     = disp.instr2;
      pcplus4_o    = PC_W'(disp.pc) + PC_W'(4);
      nextpc_sel_o = disp.stream_new;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [15:0] imem_addr, redirect_pc, pcplus4_o;
  logic [63:0] imem_rdata;
  logic        redirect_valid, deq_en, pair_valid_o, nextpc_sel_o;
  logic [31:0] instr1_o, instr2_o;

  logic        w_req, w_ready, w_rvalid, w_redirect, w_deq, w_valid, w_sel;
  logic [15:0] w_addr, w_redirect_pc, w_pcplus4;
  logic [63:0] w_rdata;
  logic [31:0] w_instr1, w_instr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_en(deq_en), .pair_valid_o(pair_valid_o), .instr1_o(instr1_o),
    .instr2_o(instr2_o), .pcplus4_o(pcplus4_o), .nextpc_sel_o(nextpc_sel_o)
  );

  fetch_unit #(.RESET_PC(16'hFFF8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .deq_en(w_deq), .pair_valid_o(w_valid), .instr1_o(w_instr1),
    .instr2_o(w_instr2), .pcplus4_o(w_pcplus4), .nextpc_sel_o(w_sel)
  );

  // Memory contents: low word A000_<addr>, high word B000_<addr+4>.
  function automatic logic [63:0] mem(input logic [15:0] a);
    logic [15:0] a4;
    a4 = a + 16'd4;
    return {16'hB000, a4, 16'hA000, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; deq_en = 1'b0;
    w_ready = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
    w_redirect = 1'b0; w_redirect_pc = '0; w_deq = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    do_reset();
    chk("rst_req",    64'(imem_req),     64'd0);
    chk("rst_valid",  64'(pair_valid_o), 64'd0);
    chk("rst_instr1", 64'(instr1_o),     64'd0);
    chk("rst_pcp4",   64'(pcplus4_o),    64'd0);
    chk("rst_sel",    64'(nextpc_sel_o), 64'd0);

    // Streaming fetch from address 0
    rst_n = 1'b1; imem_ready = 1'b1;
    tick();
    chk("s_req0",  64'(imem_req),  64'd1);
    chk("s_addr0", 64'(imem_addr), 64'h0000);
    deq_en = 1'b1;                          // empty queue: no effect
    tick();
    deq_en = 1'b0;
    chk("s_wait_req", 64'(imem_req), 64'd0);
    imem_rvalid = 1'b1; imem_rdata = mem(16'h0000);
    #1;
`ifdef FETCH_BYPASS_EN
    chk("s_bypass_show", 64'(pair_valid_o), 64'd1);
`else
    chk("s_nobypass", 64'(pair_valid_o), 64'd0);
`endif
    tick();
    imem_rvalid = 1'b0;
    chk("s_valid", 64'(pair_valid_o), 64'd1);
    chk("s_i1",    64'(instr1_o),     64'hA000_0000);
    chk("s_i2",    64'(instr2_o),     64'hB000_0004);
    chk("s_pcp4",  64'(pcplus4_o),    64'h0004);
    chk("s_sel",   64'(nextpc_sel_o), 64'd0);
    chk("s_req1",  64'(imem_req),     64'd1);
    chk("s_addr1", 64'(imem_addr),    64'h0008);
    deq_en = 1'b1;
    tick();
    deq_en = 1'b0;
    chk("s_empty", 64'(pair_valid_o), 64'd0);
    imem_rvalid = 1'b1; imem_rdata = mem(16'h0008);
    tick();
    imem_rvalid = 1'b0;
    chk("s_addr2", 64'(imem_addr), 64'h0010);
    chk("s_pcp4_2", 64'(pcplus4_o), 64'h000C);
    chk("s_i1_2",  64'(instr1_o),  64'hA000_0008);

    // Backpressure: four pairs fill the queue
    do_reset();
    rst_n = 1'b1; imem_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_req",  64'(imem_req),  64'd1);
      chk("bp_addr", 64'(imem_addr), 64'(i * 8));
      tick();
      imem_rvalid = 1'b1; imem_rdata = mem(16'(i * 8));
      tick();
      imem_rvalid = 1'b0;
    end
    chk("bp_full_req", 64'(imem_req),  64'd0);
    chk("bp_head",     64'(pcplus4_o), 64'h0004);
    tick();
    chk("bp_hold_req", 64'(imem_req), 64'd0);
    deq_en = 1'b1;
    tick();
    deq_en = 1'b0;
    chk("bp_pop_pcp4", 64'(pcplus4_o), 64'h000C);
    chk("bp_newreq",   64'(imem_req),  64'd1);
    chk("bp_newaddr",  64'(imem_addr), 64'h0020);
    tick();
    chk("bp_wait_req", 64'(imem_req), 64'd0);
    tick();
    chk("bp_wait_req2", 64'(imem_req), 64'd0);
    imem_rvalid = 1'b1; imem_rdata = mem(16'h0020);
    tick();
    imem_rvalid = 1'b0;
    chk("bp_refull_req", 64'(imem_req),  64'd0);
    chk("bp_head2",      64'(pcplus4_o), 64'h000C);

    // Redirect to 0x0124 with a response outstanding
    do_reset();
    rst_n = 1'b1; imem_ready = 1'b1;
    tick();
    tick();
    chk("rd_wait_req", 64'(imem_req), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 16'h0124;
    tick();
    redirect_valid = 1'b0;
    chk("rd_drain_req", 64'(imem_req),     64'd0);
    chk("rd_empty",     64'(pair_valid_o), 64'd0);
    tick();
    chk("rd_drain_hold", 64'(imem_req), 64'd0);
    imem_rvalid = 1'b1; imem_rdata = mem(16'h0000);
    tick();
    imem_rvalid = 1'b0;
    chk("rd_discard", 64'(pair_valid_o), 64'd0);
    chk("rd_req",     64'(imem_req),     64'd1);
    chk("rd_addr",    64'(imem_addr),    64'h0120);
    tick();
    imem_rvalid = 1'b1; imem_rdata = mem(16'h0120);
    tick();
    imem_rvalid = 1'b0;
    chk("rd_i1",    64'(instr1_o),     64'h0);
    chk("rd_i2",    64'(instr2_o),     64'hB000_0124);
    chk("rd_pcp4",  64'(pcplus4_o),    64'h0124);
    chk("rd_sel",   64'(nextpc_sel_o), 64'd1);
    chk("rd_addr2", 64'(imem_addr),    64'h0128);
    tick();
    imem_rvalid = 1'b1; imem_rdata = mem(16'h0128); deq_en = 1'b1;
    tick();
    imem_rvalid = 1'b0; deq_en = 1'b0;
    chk("rd_pop_valid", 64'(pair_valid_o), 64'd1);
    chk("rd_pop_pcp4",  64'(pcplus4_o),    64'h012C);
    chk("rd_pop_sel",   64'(nextpc_sel_o), 64'd0);
    chk("rd_pop_i1",    64'(instr1_o),     64'hA000_0128);

    // Redirect + rvalid + deq_en in one cycle, three pairs queued
    do_reset();
    rst_n = 1'b1; imem_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_rvalid = 1'b1; imem_rdata = mem(16'(i * 8));
      tick();
      imem_rvalid = 1'b0;
    end
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    imem_rvalid = 1'b1; imem_rdata = mem(16'h0018); deq_en = 1'b1;
    tick();
    redirect_valid = 1'b0; imem_rvalid = 1'b0; deq_en = 1'b0;
    chk("sim_valid", 64'(pair_valid_o), 64'd0);
    chk("sim_pcp4",  64'(pcplus4_o),    64'h0);
    chk("sim_req",   64'(imem_req),     64'd1);
    chk("sim_addr",  64'(imem_addr),    64'h0040);
    tick();
    imem_rvalid = 1'b1; imem_rdata = mem(16'h0040);
    tick();
    imem_rvalid = 1'b0;
    chk("sim_pcp4b", 64'(pcplus4_o),    64'h0044);
    chk("sim_sel",   64'(nextpc_sel_o), 64'd1);
    chk("sim_i1",    64'(instr1_o),     64'hA000_0040);

    // PC wrap on the RESET_PC=16'hFFF8 instance
    do_reset();
    rst_n = 1'b1; w_ready = 1'b1;
    tick();
    chk("w_req",   64'(w_req),  64'd1);
    chk("w_addr0", 64'(w_addr), 64'hFFF8);
    tick();
    w_rvalid = 1'b1; w_rdata = mem(16'hFFF8);
    tick();
    w_rvalid = 1'b0;
    chk("w_addr1", 64'(w_addr),    64'h0000);
    chk("w_pcp4",  64'(w_pcplus4), 64'hFFFC);
    chk("w_i1",    64'(w_instr1),  64'hA000_FFF8);
    chk("w_i2",    64'(w_instr2),  64'hB000_FFFC);

`ifdef FETCH_BYPASS_EN
    // Bypass: empty queue, rvalid with deq_en consumes the pair directly
    do_reset();
    rst_n = 1'b1; imem_ready = 1'b1;
    tick();
    tick();
    imem_rvalid = 1'b1; imem_rdata = mem(16'h0000); deq_en = 1'b1;
    #1;
    chk("by_valid", 64'(pair_valid_o), 64'd1);
    chk("by_i1",    64'(instr1_o),     64'hA000_0000);
    chk("by_i2",    64'(instr2_o),     64'hB000_0004);
    chk("by_pcp4",  64'(pcplus4_o),    64'h0004);
    tick();
    imem_rvalid = 1'b0; deq_en = 1'b0;
    chk("by_after_valid", 64'(pair_valid_o), 64'd0);
    chk("by_next_addr",   64'(imem_addr),    64'h0008);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
